eth_send_gmii: RTL and testbench
================================

Name: eth_send_gmii

Overview:
- GMII Ethernet frame transmitter on a single clock.
- On a start pulse it serialises, one byte per clock:
  - preamble and SFD;
  - destination MAC, source MAC and EtherType;
  - a payload pulled from a show-ahead byte FIFO;
  - a caller-supplied 4-byte FCS.
- After the frame it enforces an inter-frame gap before accepting the next start.
- It sits between packet-building logic (which supplies the header fields, payload FIFO and precomputed FCS) and the PHY's GMII transmit interface.

Parameters:
- PREAMBLE_LEN, 7: number of 0x55 bytes sent before the SFD byte 0xD5.
- IFG_CYCLES, 12: idle cycles (gmii_tx_en low) after the last FCS byte before a new tx_en is accepted.

Ports:
- gmii_tx_clk  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tx_en  in  1  start pulse; sampled only in IDLE.
- target_mac_addr  in  48  destination MAC; bits [47:40] are sent first.
- src_mac_addr  in  48  source MAC; bits [47:40] are sent first.
- frame_type  in  16  EtherType; bits [15:8] are sent first.
- fsc  in  32  FCS bytes in wire order; fsc[31:24] is sent first.
- fifo_data_length  in  16  payload byte count L.
- fifo_rdreq  out  1  payload read strobe.
- fifo_data  in  8  payload byte; show-ahead (valid in the same cycle rdreq is high).
- fifo_rdclk  out  1  payload FIFO read clock; equals gmii_tx_clk.
- gmii_tx_data  out  8  GMII transmit data, registered.
- gmii_tx_en  out  1  GMII transmit enable, registered.
- gmii_tx_er  out  1  GMII transmit error; constant 0.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state = IDLE; gmii_tx_en = 0; gmii_tx_data = 0x00; fifo_rdreq = 0; all counters = 0.
  - A frame in progress is abandoned; no resumption after reset release.
- States: IDLE, PREAMBLE, SFD, DST, SRC, TYPE, DATA, FCS, IFG.
- IDLE:
  - If tx_en = 1 at edge E0, latch target_mac_addr, src_mac_addr, frame_type, fsc and fifo_data_length; go to PREAMBLE.
  - Inputs changing after E0 do not affect the current frame.
- Wire byte index i (0-based) is driven on gmii_tx_data with gmii_tx_en = 1 after edge E0+1+i. Total bytes N = PREAMBLE_LEN + 1 + 14 + L + 4; gmii_tx_en is high for exactly N consecutive cycles.
- Byte order:
  - PREAMBLE_LEN × 0x55, then 0xD5.
  - target MAC MSB byte first (6 bytes), then src MAC (6), then frame_type hi, lo.
  - L payload bytes.
  - fsc[31:24], [23:16], [15:8], [7:0].
- Payload timing:
  - fifo_rdreq is high for exactly L consecutive cycles.
  - Payload byte k is taken from fifo_data while rdreq is high (the k-th rdreq cycle) and is registered onto gmii_tx_data at that cycle's ending edge, so payload bytes are contiguous with the TYPE and FCS bytes.
  - The first rdreq cycle is the one whose ending edge outputs wire index PREAMBLE_LEN+15.
- L = 0: DATA is skipped; FCS follows TYPE directly; fifo_rdreq never asserts.
- No padding and no FCS computation: the caller supplies a payload of at least 46 bytes and the correct fsc.
- L counting uses a 16-bit counter; no wrap within one frame.
- After the last FCS byte:
  - gmii_tx_en = 0 and gmii_tx_data = 0x00.
  - Stay in IFG for IFG_CYCLES cycles, then return to IDLE.
- tx_en in any non-IDLE state (including IFG) is ignored and not queued.
- gmii_tx_er is always 0; fifo_rdclk is combinationally wired to gmii_tx_clk.

Test Plan:
1. Reset asserted then released, no tx_en → gmii_tx_en = 0, gmii_tx_data = 0x00, fifo_rdreq = 0, gmii_tx_er = 0 for 100 cycles.
2. ARP broadcast frame. Stimulus: tx_en pulse with target FF:FF:FF:FF:FF:FF, src 00:07:ED:AC:62:00, type 0x0806, fsc = 0xBB1C7CBE, L = 46, FIFO returning bytes 00 01 08 00 … 00 01. Required response:
   - gmii_tx_en high for 72 cycles starting 1 cycle after the tx_en sample.
   - Bytes 0–6 = 55, 7 = D5, 8–13 = FF, 14–19 = 00 07 ED AC 62 00, 20–21 = 08 06.
   - Bytes 22–67 = payload in order; 68–71 = BB 1C 7C BE.
   - fifo_rdreq high exactly 46 cycles.
3. Back-to-back: tx_en held high continuously → frames separated by exactly 12 idle cycles plus the 1-cycle IDLE start latency, each frame identical to scenario 2.
4. tx_en pulsed during DATA and during IFG → no extra frame; the next frame starts only on a tx_en seen in IDLE.
5. L = 0 → 26-byte frame; FCS at bytes 22–25; fifo_rdreq never high.
6. rst_n asserted during byte 30 → outputs return to reset values immediately (asynchronously); after release, a new tx_en produces a complete, correct frame.

Source files
------------

// File: rtl/eth_send_gmii.sv
// eth_send_gmii: GMII frame transmitter serialising preamble, SFD, header, FIFO payload and caller FCS, then an inter-frame gap.
module eth_send_gmii #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_CYCLES   = 12
) (
  input  logic        gmii_tx_clk,
  input  logic        rst_n,
  input  logic        tx_en,
  input  logic [47:0] target_mac_addr,
  input  logic [47:0] src_mac_addr,
  input  logic [15:0] frame_type,
  input  logic [31:0] fsc,
  input  logic [15:0] fifo_data_length,
  output logic        fifo_rdreq,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rdclk,
  output logic [7:0]  gmii_tx_data,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er
);
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] PREAMBLE = 4'd1;
  localparam logic [3:0] SFD      = 4'd2;
  localparam logic [3:0] DST      = 4'd3;
  localparam logic [3:0] SRC      = 4'd4;
  localparam logic [3:0] TYPE     = 4'd5;
  localparam logic [3:0] DATA     = 4'd6;
  localparam logic [3:0] FCS      = 4'd7;
  localparam logic [3:0] IFG      = 4'd8;

  logic [3:0]   state_q, state_d;
  logic [15:0]  cnt_q, cnt_d, len_q, len_d;
  logic [111:0] hdr_q, hdr_d;
  logic [31:0]  fsc_q, fsc_d;
  logic [7:0]   data_q, data_d;
  logic         en_q, en_d;

  // Each state produces the byte that the next edge registers onto the wire.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    hdr_d   = hdr_q;
    fsc_d   = fsc_q;
    len_d   = len_q;
    data_d  = 8'h00;
    en_d    = 1'b1;
    case (state_q)
      IDLE: begin
        en_d  = 1'b0;
        cnt_d = '0;
        if (tx_en) begin
          state_d = PREAMBLE;
          hdr_d   = {target_mac_addr, src_mac_addr, frame_type};
          fsc_d   = fsc;
          len_d   = fifo_data_length;
        end
      end
      PREAMBLE: begin
        data_d = 8'h55;
        if (cnt_q == 16'(PREAMBLE_LEN - 1)) begin
          state_d = SFD;
          cnt_d   = '0;
        end
      end
      SFD: begin
        data_d  = 8'hD5;
        state_d = DST;
        cnt_d   = '0;
      end
      DST, SRC, TYPE: begin
        data_d = hdr_q[111:104];
        hdr_d  = {hdr_q[103:0], 8'h00};
        if (state_q == TYPE ? cnt_q == 16'd1 : cnt_q == 16'd5) begin
          state_d = state_q == DST ? SRC : state_q == SRC ? TYPE : len_q == 16'd0 ? FCS : DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        data_d = fifo_data;
        if (cnt_q == len_q - 16'd1) begin
          state_d = FCS;
          cnt_d   = '0;
        end
      end
      FCS: begin
        data_d = fsc_q[31:24];
        fsc_d  = {fsc_q[23:0], 8'h00};
        if (cnt_q == 16'd3) begin
          state_d = IFG;
          cnt_d   = '0;
        end
      end
      IFG: begin
        en_d = 1'b0;
        if (cnt_q == 16'(IFG_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        en_d    = 1'b0;
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      hdr_q   <= '0;
      fsc_q   <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      hdr_q   <= hdr_d;
      fsc_q   <= fsc_d;
      data_q  <= data_d;
      en_q    <= en_d;
    end
  end

  assign fifo_rdreq   = state_q == DATA;
  assign fifo_rdclk   = gmii_tx_clk;
  assign gmii_tx_data = data_q;
  assign gmii_tx_en   = en_q;
  assign gmii_tx_er   = 1'b0;
endmodule

// File: tb/tb_eth_send_gmii.sv
// tb_eth_send_gmii: directed bench for eth_send_gmii with a show-ahead FIFO model and hand-listed wire bytes.
module tb_eth_send_gmii;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_en;
  logic [47:0] target_mac_addr, src_mac_addr;
  logic [15:0] frame_type, fifo_data_length;
  logic [31:0] fsc;
  logic        fifo_rdreq, fifo_rdclk, gmii_tx_en, gmii_tx_er;
  logic [7:0]  fifo_data, gmii_tx_data;

  int checks = 0;
  int fails  = 0;
  int rd_idx = 0;
  logic [7:0] pay [46];
  logic [7:0] pre [22] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
                           8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                           8'h00, 8'h07, 8'hED, 8'hAC, 8'h62, 8'h00, 8'h08, 8'h06};
  logic [7:0] fcs_b [4] = '{8'hBB, 8'h1C, 8'h7C, 8'hBE};

  eth_send_gmii dut (
    .gmii_tx_clk(clk), .rst_n(rst_n), .tx_en(tx_en),
    .target_mac_addr(target_mac_addr), .src_mac_addr(src_mac_addr),
    .frame_type(frame_type), .fsc(fsc), .fifo_data_length(fifo_data_length),
    .fifo_rdreq(fifo_rdreq), .fifo_data(fifo_data), .fifo_rdclk(fifo_rdclk),
    .gmii_tx_data(gmii_tx_data), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er)
  );

  always #4 clk = ~clk;

  // Show-ahead FIFO: head byte always visible, pops on each rdreq edge, rewinds when the line is idle.
  always @(posedge clk) rd_idx <= fifo_rdreq ? rd_idx + 1 : (gmii_tx_en ? rd_idx : 0);
  assign fifo_data = rd_idx < 46 ? pay[rd_idx] : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i, input int l);
    if (i < 22) return pre[i];
    if (i < 22 + l) return pay[i - 22];
    return fcs_b[i - 22 - l];
  endfunction

  task automatic set_fields(input int l);
    target_mac_addr  = 48'hFFFF_FFFF_FFFF;
    src_mac_addr     = 48'h0007_EDAC_6200;
    frame_type       = 16'h0806;
    fsc              = 32'hBB1C_7CBE;
    fifo_data_length = 16'(l);
  endtask

  task automatic start(input int l);
    set_fields(l);
    tx_en = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    chk("start_latency_en", 32'(gmii_tx_en), 32'd0);
    target_mac_addr  = 48'h1234_5678_9ABC;
    src_mac_addr     = 48'hDEAD_BEEF_0001;
    frame_type       = 16'h86DD;
    fsc              = 32'h0;
    fifo_data_length = 16'd3;
  endtask

  task automatic run_frame(input int l, input int gap_exp, input int poke, input int abort);
    int gap = 0;
    int n = 7 + 1 + 14 + l + 4;
    do begin
      @(negedge clk);
      gap++;
    end while (gmii_tx_en !== 1'b1 && gap < 300);
    chk("gap_before_frame", 32'(gap), 32'(gap_exp));
    for (int i = 0; i < n; i++) begin
      if (i == abort) begin
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({gmii_tx_en, gmii_tx_data, fifo_rdreq}), 32'd0);
        return;
      end
      chk($sformatf("tx_en[%0d]", i), 32'(gmii_tx_en), 32'd1);
      chk($sformatf("tx_data[%0d]", i), 32'(gmii_tx_data), 32'(exp_byte(i, l)));
      chk($sformatf("rdreq[%0d]", i), 32'(fifo_rdreq), 32'(i >= 21 && i < 21 + l));
      if (i == poke) tx_en = 1'b1;
      if (i == poke + 1) tx_en = 1'b0;
      @(negedge clk);
    end
    chk("post_frame_en", 32'(gmii_tx_en), 32'd0);
    chk("post_frame_data", 32'(gmii_tx_data), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 46; k++) pay[k] = 8'(k * 5 + 1);
    pay[0] = 8'h00; pay[1] = 8'h01; pay[2] = 8'h08; pay[3] = 8'h00;
    pay[44] = 8'h00; pay[45] = 8'h01;
    rst_n = 1'b0;
    tx_en = 1'b0;
    set_fields(46);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("idle_outputs", 32'({gmii_tx_en, gmii_tx_data, fifo_rdreq, gmii_tx_er}), 32'd0);
    end
    start(46);
    run_frame(46, 1, -10, -1);
    repeat (15) @(negedge clk);
    set_fields(46);
    tx_en = 1'b1;
    run_frame(46, 2, -10, -1);
    run_frame(46, 13, -10, -1);
    tx_en = 1'b0;
    repeat (15) @(negedge clk);
    start(46);
    run_frame(46, 1, 30, -1);
    tx_en = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("no_frame_after_ignored_tx_en", 32'(gmii_tx_en), 32'd0);
    end
    start(46);
    run_frame(46, 1, -10, -1);
    repeat (15) @(negedge clk);
    start(0);
    run_frame(0, 1, -10, -1);
    repeat (15) @(negedge clk);
    start(46);
    run_frame(46, 1, -10, 30);
    repeat (3) @(negedge clk);
    chk("held_reset_outputs", 32'({gmii_tx_en, gmii_tx_data, fifo_rdreq}), 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_reset_idle", 32'({gmii_tx_en, gmii_tx_data, fifo_rdreq}), 32'd0);
    end
    start(46);
    run_frame(46, 1, -10, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
